fractal_palette_colorizer: RTL and testbench

FRACTAL_PALETTE_COLORIZER -- requirements
Module: fractal_palette_colorizer

---
 rtl/fractal_palette_colorizer.sv | 172 +++++++++++++++++
 tb/tb_fractal_palette_colorizer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_palette_colorizer.sv
// Fractal palette colorizer: maps iteration-count pixels to 24-bit RGB using
// fixed tint modes or a writable palette, with a fixed 2-cycle pipeline.
// Optional palette cycling is built when FRACTAL_PALETTE_COLORIZER_CYCLE_EN is defined.
module fractal_palette_colorizer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned PAL_ADDR_WIDTH  = 8,
    parameter int unsigned CYCLE_DIV_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 mode,
    input  logic [CYCLE_DIV_WIDTH-1:0] cycle_div,
    input  logic                       interior_black,
    input  logic                       pal_we,
    input  logic [PAL_ADDR_WIDTH-1:0]  pal_addr,
    input  logic [23:0]                pal_wdata,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       frame_start_in,
    input  logic                       line_end_in,
    input  logic                       data_enable_in,
    output logic [23:0]                data_out,
    output logic                       frame_start_out,
    output logic                       line_end_out,
    output logic                       data_enable_out
);

    localparam int unsigned PalDepth = 2 ** PAL_ADDR_WIDTH;

    // Frame settings: live on the frame-start cycle, latched otherwise
    logic [3:0]                mode_q;
    logic                      black_q;
    logic [3:0]                mode_eff;
    logic                      black_eff;
    logic [PAL_ADDR_WIDTH-1:0] offset;

    // Select live or latched frame settings
    always_comb begin
        mode_eff  = frame_start_in ? mode : mode_q;
        black_eff = frame_start_in ? interior_black : black_q;
    end

    // Latch frame settings at frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= 4'd0;
            black_q <= 1'b0;
        end else if (frame_start_in) begin
            mode_q  <= mode;
            black_q <= interior_black;
        end
    end

`ifdef FRACTAL_PALETTE_COLORIZER_CYCLE_EN
    // The divider only matters on frame-start cycles, where the live value is the
    // effective one, so no latched copy of cycle_div is needed.
    logic [CYCLE_DIV_WIDTH-1:0] fcnt_q;
    logic [CYCLE_DIV_WIDTH-1:0] fcnt_inc;
    logic [PAL_ADDR_WIDTH-1:0]  offset_q;

    assign fcnt_inc = fcnt_q + CYCLE_DIV_WIDTH'(1);
    assign offset   = offset_q;

    // Advance the frame counter and palette offset once per frame
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q   <= '0;
            offset_q <= '0;
        end else if (frame_start_in) begin
            if (cycle_div == '0) begin
                fcnt_q <= '0;
            end else if (fcnt_inc == cycle_div) begin
                fcnt_q   <= '0;
                offset_q <= offset_q + PAL_ADDR_WIDTH'(1);
            end else begin
                fcnt_q <= fcnt_inc;
            end
        end
    end
`else
    logic unused_cycle_div;

    assign offset           = '0;
    assign unused_cycle_div = ^cycle_div;
`endif

    // Palette RAM with registered, read-first output
    logic [23:0]               pal_mem [PalDepth];
    logic [23:0]               pal_rd_q;
    logic [PAL_ADDR_WIDTH-1:0] pal_idx;

    // Offset used here is the pre-update value, even on the frame-start cycle
    assign pal_idx = data_in[DATA_WIDTH-1 -: PAL_ADDR_WIDTH] + offset;

    // Palette write port; contents survive reset and writes during reset are dropped
    always_ff @(posedge clk) begin
        if (pal_we && !reset) begin
            pal_mem[pal_addr] <= pal_wdata;
        end
    end

    // Palette synchronous read (stage 1)
    always_ff @(posedge clk) begin
        if (reset) begin
            pal_rd_q <= '0;
        end else begin
            pal_rd_q <= pal_mem[pal_idx];
        end
    end

    // Stage 1 registers
    logic [7:0] s1_g_q;
    logic [3:0] s1_mode_q;
    logic       s1_black_q;
    logic       s1_fs_q;
    logic       s1_le_q;
    logic       s1_de_q;

    // Capture pixel intensity, effective mode and sidebands
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_g_q     <= 8'd0;
            s1_mode_q  <= 4'd0;
            s1_black_q <= 1'b0;
            s1_fs_q    <= 1'b0;
            s1_le_q    <= 1'b0;
            s1_de_q    <= 1'b0;
        end else begin
            s1_g_q     <= data_in[DATA_WIDTH-1 -: 8];
            s1_mode_q  <= mode_eff;
            s1_black_q <= black_eff && (&data_in);
            s1_fs_q    <= frame_start_in;
            s1_le_q    <= line_end_in;
            s1_de_q    <= data_enable_in;
        end
    end

    logic [23:0] rgb_d;

    // Colour mapping; modes 8..15 fall back to gray
    always_comb begin
        rgb_d = {s1_g_q, s1_g_q, s1_g_q};
        case (s1_mode_q)
            4'd1:    rgb_d = {s1_g_q, 8'h00, 8'h00};
            4'd2:    rgb_d = {8'h00, s1_g_q, 8'h00};
            4'd3:    rgb_d = {8'h00, 8'h00, s1_g_q};
            4'd4:    rgb_d = {s1_g_q, s1_g_q, 8'h00};
            4'd5:    rgb_d = {8'h00, s1_g_q, s1_g_q};
            4'd6:    rgb_d = {s1_g_q, 8'h00, s1_g_q};
            4'd7:    rgb_d = pal_rd_q;
            default: ;
        endcase
        if (s1_black_q) begin
            rgb_d = 24'h000000;
        end
    end

    // Stage 2 output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out        <= 24'h000000;
            frame_start_out <= 1'b0;
            line_end_out    <= 1'b0;
            data_enable_out <= 1'b0;
        end else begin
            data_out        <= rgb_d;
            frame_start_out <= s1_fs_q;
            line_end_out    <= s1_le_q;
            data_enable_out <= s1_de_q;
        end
    end

endmodule

// File: tb/tb_fractal_palette_colorizer.sv
// Self-checking bench for fractal_palette_colorizer: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_fractal_palette_colorizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mode;
    logic [7:0]  cycle_div;
    logic        interior_black;
    logic        pal_we;
    logic [7:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic [7:0]  data_in;
    logic        frame_start_in;
    logic        line_end_in;
    logic        data_enable_in;
    logic [23:0] data_out;
    logic        frame_start_out;
    logic        line_end_out;
    logic        data_enable_out;

    // Second instance with 10-bit pixels
    logic        b_reset;
    logic [3:0]  b_mode;
    logic        b_black;
    logic [9:0]  b_data;
    logic        b_fs;
    logic [7:0]  b_zero8;
    logic [23:0] b_zero24;
    logic        b_zero;
    logic [23:0] b_data_out;
    logic        b_fs_out;
    logic        b_le_out;
    logic        b_de_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fractal_palette_colorizer dut (
        .clk            (clk),
        .reset          (reset),
        .mode           (mode),
        .cycle_div      (cycle_div),
        .interior_black (interior_black),
        .pal_we         (pal_we),
        .pal_addr       (pal_addr),
        .pal_wdata      (pal_wdata),
        .data_in        (data_in),
        .frame_start_in (frame_start_in),
        .line_end_in    (line_end_in),
        .data_enable_in (data_enable_in),
        .data_out       (data_out),
        .frame_start_out(frame_start_out),
        .line_end_out   (line_end_out),
        .data_enable_out(data_enable_out)
    );

    fractal_palette_colorizer #(.DATA_WIDTH(10)) dut10 (
        .clk            (clk),
        .reset          (b_reset),
        .mode           (b_mode),
        .cycle_div      (b_zero8),
        .interior_black (b_black),
        .pal_we         (b_zero),
        .pal_addr       (b_zero8),
        .pal_wdata      (b_zero24),
        .data_in        (b_data),
        .frame_start_in (b_fs),
        .line_end_in    (b_zero),
        .data_enable_in (b_zero),
        .data_out       (b_data_out),
        .frame_start_out(b_fs_out),
        .line_end_out   (b_le_out),
        .data_enable_out(b_de_out)
    );

    // Behavioural model state
    logic [23:0] pal_m [256];
    logic [26:0] exp_q [$];
    int          m_mode;
    bit          m_black;
    int          m_fcnt;
    int          m_off;

    // One clock: model predicts, DUT advances; returns {rgb, fs, le, de} pairs
    task automatic tick(output logic [26:0] act, output logic [26:0] exp);
        int          eff_mode;
        bit          eff_black;
        int          idx;
        logic [7:0]  g;
        logic [23:0] rgb;
        if (reset) begin
            exp = '0;
            exp_q.delete();
            exp_q.push_back('0);
            m_mode  = 0;
            m_black = 0;
            m_fcnt  = 0;
            m_off   = 0;
        end else begin
            eff_mode  = frame_start_in ? int'(mode) : m_mode;
            eff_black = frame_start_in ? interior_black : m_black;
            idx       = (int'(data_in) + m_off) % 256;
            g         = data_in;
            case (eff_mode)
                1:       rgb = {g, 8'h00, 8'h00};
                2:       rgb = {8'h00, g, 8'h00};
                3:       rgb = {8'h00, 8'h00, g};
                4:       rgb = {g, g, 8'h00};
                5:       rgb = {8'h00, g, g};
                6:       rgb = {g, 8'h00, g};
                7:       rgb = pal_m[idx];
                default: rgb = {g, g, g};
            endcase
            if (eff_black && data_in == 8'hFF) rgb = 24'h000000;
            exp_q.push_back({rgb, frame_start_in, line_end_in, data_enable_in});
            exp = exp_q.pop_front();
            if (frame_start_in) begin
                m_mode  = int'(mode);
                m_black = interior_black;
`ifdef FRACTAL_PALETTE_COLORIZER_CYCLE_EN
                if (cycle_div == 8'd0) begin
                    m_fcnt = 0;
                end else if ((m_fcnt + 1) % 256 == int'(cycle_div)) begin
                    m_fcnt = 0;
                    m_off  = (m_off + 1) % 256;
                end else begin
                    m_fcnt = (m_fcnt + 1) % 256;
                end
`endif
            end
            if (pal_we) pal_m[pal_addr] = pal_wdata;
        end
        @(posedge clk);
        #1;
        act = {data_out, frame_start_out, line_end_out, data_enable_out};
    endtask

    task automatic idle_inputs();
        reset          = 1'b0;
        mode           = 4'd0;
        cycle_div      = 8'd0;
        interior_black = 1'b0;
        pal_we         = 1'b0;
        pal_addr       = 8'd0;
        pal_wdata      = 24'd0;
        data_in        = 8'd0;
        frame_start_in = 1'b0;
        line_end_in    = 1'b0;
        data_enable_in = 1'b0;
    endtask

    task automatic do_reset();
        logic [26:0] act, exp;
        idle_inputs();
        reset = 1'b1;
        tick(act, exp);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] act, exp;
        idle_inputs();
        data_in        = 8'hC3;
        data_enable_in = 1'b1;
        frame_start_in = 1'b1;
        reset          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(act, exp);
            n_tests++;
            if (act !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_state: got %h expected %h", act, 27'd0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_red_latency();
        logic [26:0] act, exp;
        do_reset();
        frame_start_in = 1'b1;
        mode           = 4'd1;
        data_in        = 8'hA5;
        data_enable_in = 1'b1;
        tick(act, exp);
        n_tests++;
        if (act !== 27'd0) begin
            n_fail++;
            $display("FAIL red_latency_early: got %h expected %h", act, 27'd0);
        end
        frame_start_in = 1'b0;
        data_enable_in = 1'b0;
        data_in        = 8'h00;
        tick(act, exp);
        n_tests++;
        if (act !== {24'hA50000, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL red_latency: got %h expected %h", act,
                     {24'hA50000, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_mode_latch();
        logic [26:0] act, exp;
        logic [26:0] want [6];
        want[0] = {24'h3C3C3C, 1'b1, 1'b0, 1'b1};
        want[1] = {24'h3C3C3C, 1'b0, 1'b0, 1'b1};
        want[2] = {24'h3C3C3C, 1'b0, 1'b0, 1'b1};
        want[3] = {24'h3C3C3C, 1'b0, 1'b0, 1'b1};
        want[4] = {24'h3C3C00, 1'b1, 1'b0, 1'b1};
        want[5] = {24'h3C3C00, 1'b0, 1'b0, 1'b1};
        do_reset();
        data_in        = 8'h3C;
        data_enable_in = 1'b1;
        frame_start_in = 1'b1;
        mode           = 4'd0;
        tick(act, exp);
        for (int i = 0; i < 6; i++) begin
            frame_start_in = (i == 3);
            mode           = 4'd4;
            tick(act, exp);
            n_tests++;
            if (act !== want[i]) begin
                n_fail++;
                $display("FAIL mode_latch[%0d]: got %h expected %h", i, act, want[i]);
            end
        end
    endtask

    task automatic test_cycling();
        logic [26:0] act, exp;
        logic [7:0]  v;
        int          offs [6];
`ifdef FRACTAL_PALETTE_COLORIZER_CYCLE_EN
        offs = '{0, 0, 1, 1, 2, 2};
`else
        offs = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        for (int i = 0; i < 256; i++) begin
            pal_we    = 1'b1;
            pal_addr  = 8'(i);
            pal_wdata = {8'(i), 8'(i), 8'(i)};
            tick(act, exp);
        end
        pal_we = 1'b0;
        for (int f = 0; f < 6; f++) begin
            frame_start_in = 1'b1;
            mode           = 4'd7;
            cycle_div      = 8'd2;
            data_in        = 8'hFF;
            data_enable_in = 1'b1;
            tick(act, exp);
            frame_start_in = 1'b0;
            cycle_div      = 8'd0;
            data_in        = 8'h00;
            tick(act, exp);
            v = 8'(255 + offs[f]);
            n_tests++;
            if (act !== {v, v, v, 1'b1, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL cycling[%0d]: got %h expected %h", f, act,
                         {v, v, v, 1'b1, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_palette_rw();
        logic [26:0] act, exp;
        do_reset();
        pal_we         = 1'b1;
        pal_addr       = 8'h10;
        pal_wdata      = 24'h123456;
        tick(act, exp);
        pal_we         = 1'b0;
        frame_start_in = 1'b1;
        mode           = 4'd7;
        data_in        = 8'h10;
        data_enable_in = 1'b1;
        tick(act, exp);
        pal_we         = 1'b1;
        pal_wdata      = 24'hABCDEF;
        tick(act, exp);
        n_tests++;
        if (act !== {24'h123456, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL palette_read: got %h expected %h", act,
                     {24'h123456, 1'b1, 1'b0, 1'b1});
        end
        pal_we         = 1'b0;
        frame_start_in = 1'b0;
        tick(act, exp);
        n_tests++;
        if (act !== {24'h123456, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL palette_read_first: got %h expected %h", act,
                     {24'h123456, 1'b1, 1'b0, 1'b1});
        end
        tick(act, exp);
        n_tests++;
        if (act !== {24'hABCDEF, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL palette_new_value: got %h expected %h", act,
                     {24'hABCDEF, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_random();
        logic [26:0] act, exp;
        for (int i = 0; i < 1500; i++) begin
            frame_start_in = ($urandom_range(15) == 0);
            mode           = 4'($urandom_range(15));
            cycle_div      = 8'($urandom_range(3));
            interior_black = 1'($urandom_range(1));
            pal_we         = ($urandom_range(3) == 0);
            pal_addr       = 8'($urandom);
            pal_wdata      = 24'($urandom);
            data_in        = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
            line_end_in    = 1'($urandom_range(1));
            data_enable_in = 1'($urandom_range(1));
            tick(act, exp);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, act, exp);
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [26:0] act, exp;
        idle_inputs();
        data_enable_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame_start_in = (i == 0);
            mode           = 4'd7;
            cycle_div      = 8'd1;
            data_in        = 8'($urandom);
            tick(act, exp);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL pre_reset[%0d]: got %h expected %h", i, act, exp);
            end
        end
        frame_start_in = 1'b0;
        reset          = 1'b1;
        pal_we         = 1'b1;
        pal_addr       = 8'h20;
        pal_wdata      = 24'hDEADBE;
        tick(act, exp);
        n_tests++;
        if (act !== 27'd0) begin
            n_fail++;
            $display("FAIL midline_reset_edge: got %h expected %h", act, 27'd0);
        end
        reset   = 1'b0;
        pal_we  = 1'b0;
        mode    = 4'd3;
        data_in = 8'h5A;
        tick(act, exp);
        n_tests++;
        if (act !== 27'd0) begin
            n_fail++;
            $display("FAIL midline_reset_flush: got %h expected %h", act, 27'd0);
        end
        frame_start_in = 1'b1;
        mode           = 4'd7;
        cycle_div      = 8'd1;
        data_in        = 8'h20;
        tick(act, exp);
        n_tests++;
        if (act !== {24'h5A5A5A, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midline_post_reset_gray: got %h expected %h", act,
                     {24'h5A5A5A, 1'b0, 1'b0, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            frame_start_in = 1'b0;
            data_in        = 8'(i);
            tick(act, exp);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL midline_palette[%0d]: got %h expected %h", i, act, exp);
            end
        end
    endtask

    task automatic b_tick(output logic [26:0] act);
        @(posedge clk);
        #1;
        act = {b_data_out, b_fs_out, b_le_out, b_de_out};
    endtask

    task automatic test_interior_black();
        logic [26:0] act;
        logic [26:0] want [4];
        want[0] = {24'h000000, 1'b1, 1'b0, 1'b0};
        want[1] = {24'hFFFFFF, 1'b0, 1'b0, 1'b0};
        want[2] = {24'hFFFFFF, 1'b1, 1'b0, 1'b0};
        want[3] = {24'hFFFFFF, 1'b0, 1'b0, 1'b0};
        b_reset = 1'b1;
        b_mode  = 4'd0;
        b_black = 1'b0;
        b_data  = 10'd0;
        b_fs    = 1'b0;
        b_tick(act);
        b_reset = 1'b0;
        b_fs    = 1'b1;
        b_black = 1'b1;
        b_data  = 10'h3FF;
        b_tick(act);
        for (int i = 0; i < 4; i++) begin
            b_fs    = (i == 1);
            b_black = (i != 1);
            b_data  = (i == 0) ? 10'h3FE : 10'h3FF;
            b_tick(act);
            n_tests++;
            if (act !== want[i]) begin
                n_fail++;
                $display("FAIL interior_black10[%0d]: got %h expected %h", i, act, want[i]);
            end
        end
    endtask

    initial begin
        b_zero8  = 8'd0;
        b_zero24 = 24'd0;
        b_zero   = 1'b0;
        b_reset  = 1'b1;
        b_mode   = 4'd0;
        b_black  = 1'b0;
        b_data   = 10'd0;
        b_fs     = 1'b0;
        idle_inputs();
        test_reset();
        test_red_latency();
        test_mode_latch();
        test_cycling();
        test_palette_rw();
        test_random();
        test_reset_midline();
        idle_inputs();
        test_interior_black();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
